// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-memory port arbiter.
// The request struct is sized by the default widths.
package mem_arb_pkg;

    localparam int DEF_N  = 24;
    localparam int DEF_AW = 20;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [DEF_AW-1:0] addr;
        logic [DEF_N-1:0]  wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr, moves upward and wraps modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    grant_any
);

    localparam int IW = $clog2(NREQ);

    // The loop runs from the farthest offset down to ptr itself,
    // so the closest requester at or above ptr is assigned last and wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int pos;
            pos = i + int'(ptr);
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (req[pos[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = pos[IW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for one main-memory port.
// It can zero-fill a leading region after reset, issues one registered access per cycle
// and returns read data through a 2-stage one-hot tag pipeline.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int AW          = DEF_AW,
    parameter int NREQ        = 4,
    parameter int CLEAR_WORDS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*N-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_rdata,
    output logic [AW-1:0]     mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              mem_we,
    input  logic [N-1:0]      mem_rdata,
    output logic              init_done
);

    localparam int IW = $clog2(NREQ);
    localparam logic [AW:0] LAST_CLR = (AW+1)'((CLEAR_WORDS > 0) ? CLEAR_WORDS - 1 : 0);

    arb_state_e       state_reg, state_next;
    logic [AW:0]      clr_cnt_reg, clr_cnt_next;
    logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [AW-1:0]    mem_addr_reg, mem_addr_next;
    logic [N-1:0]     mem_wdata_reg, mem_wdata_next;
    logic             mem_we_reg, mem_we_next;
    logic             init_done_reg, init_done_next;
    logic [NREQ-1:0]  tag0_reg, tag0_next;
    logic [NREQ-1:0]  tag1_reg;

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;
    logic             arb_en;
    logic             accept;
    mem_req_t         req_vec [NREQ];
    mem_req_t         sel_req;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_vec[gi] = '{we:    req_we[gi],
                                   addr:  req_addr[gi*AW +: AW],
                                   wdata: req_wdata[gi*N +: N]};
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // rst_n gating keeps grants low while reset is held, even when the design starts in ARB.
    assign arb_en    = (state_reg == ST_ARB) && rst_n;
    assign req_ready = arb_en ? grant : '0;
    assign accept    = arb_en && grant_any;
    assign sel_req   = req_vec[grant_idx];

    always_comb begin
        state_next     = state_reg;
        clr_cnt_next   = clr_cnt_reg;
        rr_ptr_next    = rr_ptr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_we_next    = 1'b0;
        init_done_next = init_done_reg;
        tag0_next      = '0;
        case (state_reg)
            ST_CLEAR: begin
                mem_we_next    = 1'b1;
                mem_addr_next  = clr_cnt_reg[AW-1:0];
                mem_wdata_next = '0;
                clr_cnt_next   = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == LAST_CLR) begin
                    state_next     = ST_ARB;
                    init_done_next = 1'b1;
                end
            end
            ST_ARB: begin
                init_done_next = 1'b1;
                if (accept) begin
                    mem_we_next    = sel_req.we;
                    mem_addr_next  = sel_req.addr;
                    mem_wdata_next = sel_req.wdata;
                    rr_ptr_next    = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    if (!sel_req.we) begin
                        tag0_next = grant;
                    end
                end
            end
            default: state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_WORDS > 0) begin
                state_reg <= ST_CLEAR;
            end else begin
                state_reg <= ST_ARB;
            end
            clr_cnt_reg   <= '0;
            rr_ptr_reg    <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
            init_done_reg <= 1'b0;
            tag0_reg      <= '0;
            tag1_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            rr_ptr_reg    <= rr_ptr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_we_reg    <= mem_we_next;
            init_done_reg <= init_done_next;
            tag0_reg      <= tag0_next;
            tag1_reg      <= tag0_reg;
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_we    = mem_we_reg;
    assign init_done = init_done_reg;
    assign rsp_valid = tag1_reg;
    assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with an 8-word clear phase.
// A behavioural memory responds on the port.
module tb_mem_port_arbiter;

    localparam int N    = 24;
    localparam int AW   = 20;
    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_we = '0;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*N-1:0] req_wdata;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_rdata;
    logic [AW-1:0]     mem_addr;
    logic [N-1:0]      mem_wdata;
    logic              mem_we;
    logic [N-1:0]      mem_rdata;
    logic              init_done;

    logic [AW-1:0]     tb_addr  [NREQ];
    logic [N-1:0]      tb_wdata [NREQ];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_addr[gi*AW +: AW] = tb_addr[gi];
            assign req_wdata[gi*N +: N]  = tb_wdata[gi];
        end
    endgenerate

    mem_port_arbiter #(
        .N           (N),
        .AW          (AW),
        .NREQ        (NREQ),
        .CLEAR_WORDS (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    // Memory fixture: synchronous, read data one cycle after the address.
    bit [N-1:0] fx_mem [0:4095];
    always @(posedge clk) begin
        if (mem_we) fx_mem[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= fx_mem[mem_addr[11:0]];
    end

    // Reference model state.
    bit [N-1:0]      mdl_mem [0:4095];
    int              mdl_ptr = 0;
    bit              mdl_arb = 0;
    logic [NREQ-1:0] exp_tag  [2];
    logic [N-1:0]    exp_data [2];
    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [N-1:0]    exp_wdata;
    int              last_w = -1;
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int mdl_winner();
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (mdl_ptr + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic drive_cycle();
        int w;
        logic [NREQ-1:0] exp_ready;
        #1;
        w = mdl_arb ? mdl_winner() : -1;
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("init_done", init_done, 1);
        check("rsp_valid", rsp_valid, exp_tag[1]);
        if (exp_tag[1] != '0) check("rsp_rdata", rsp_rdata, exp_data[1]);
        last_w = w;
        @(posedge clk);
        exp_tag[1]  = exp_tag[0];
        exp_data[1] = exp_data[0];
        exp_tag[0]  = '0;
        if (w >= 0) begin
            exp_we    = req_we[w];
            exp_addr  = tb_addr[w];
            exp_wdata = tb_wdata[w];
            if (req_we[w]) begin
                mdl_mem[tb_addr[w][11:0]] = tb_wdata[w];
            end else begin
                exp_tag[0][w] = 1'b1;
                exp_data[0]   = mdl_mem[tb_addr[w][11:0]];
            end
            mdl_ptr = (w + 1) % NREQ;
            $display("txn t=%0t req%0d %s addr=0x%05h data=0x%06h", $time, w,
                     req_we[w] ? "WR" : "RD", tb_addr[w], tb_wdata[w]);
        end else begin
            exp_we = 1'b0;
        end
        #1;
        check("mem_we", mem_we, exp_we);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wdata", mem_wdata, exp_wdata);
        @(negedge clk);
    endtask

    task automatic clear_phase();
        for (int k = 0; k < CW; k++) begin
            #1;
            check("clr_ready", req_ready, 0);
            check("clr_init_done", init_done, 0);
            check("clr_rsp_valid", rsp_valid, 0);
            @(posedge clk);
            #1;
            check("clr_mem_we", mem_we, 1);
            check("clr_mem_addr", mem_addr, k);
            check("clr_mem_wdata", mem_wdata, 0);
            @(negedge clk);
        end
        mdl_arb   = 1;
        exp_addr  = AW'(CW - 1);
        exp_wdata = '0;
        exp_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_init_done", init_done, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rst_hold_rsp", rsp_valid, 0);
            check("rst_hold_we", mem_we, 0);
            check("rst_hold_ready", req_ready, 0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        mdl_ptr = 0;
        mdl_arb = 0;
        exp_tag[0] = '0;
        exp_tag[1] = '0;
        for (int a = 0; a < CW; a++) mdl_mem[a] = '0;
        clear_phase();
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input logic [AW-1:0] a,
                           input logic [N-1:0] d);
        req_valid[i] = v;
        req_we[i]    = we;
        tb_addr[i]   = a;
        tb_wdata[i]  = d;
    endtask

    initial begin
        exp_tag[0] = '0;
        exp_tag[1] = '0;
        exp_data[0] = '0;
        exp_data[1] = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(32 + i), N'($urandom));
        @(negedge clk);
        do_reset();

        // All four requesters streaming reads from reset.
        for (int c = 0; c < 10; c++) drive_cycle();

        // Requester 0: write then read back the same address.
        req_valid = '0;
        set_req(0, 1'b1, 1'b1, 20'h00010, 24'hABCDEF);
        drive_cycle();
        set_req(0, 1'b1, 1'b0, 20'h00010, 24'h0);
        drive_cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) drive_cycle();

        // Pointer behaviour: move rr_ptr to 0, lone request 2, then 1 and 3 together.
        set_req(3, 1'b1, 1'b0, 20'h00005, 24'h0);
        drive_cycle();
        req_valid = '0;
        set_req(2, 1'b1, 1'b0, 20'h00006, 24'h0);
        drive_cycle();
        req_valid = '0;
        set_req(1, 1'b1, 1'b0, 20'h00010, 24'h0);
        set_req(3, 1'b1, 1'b0, 20'h00007, 24'h0);
        drive_cycle();
        req_valid[3] = 1'b0;
        drive_cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) drive_cycle();

        // Requester 1 writes, requester 2 reads the same address right after.
        set_req(1, 1'b1, 1'b1, 20'h0FFFF, 24'h123456);
        drive_cycle();
        req_valid = '0;
        set_req(2, 1'b1, 1'b0, 20'h0FFFF, 24'h0);
        drive_cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) drive_cycle();

        // Reset pulsed one cycle after a read accept; the response must vanish.
        set_req(0, 1'b1, 1'b0, 20'h00010, 24'h0);
        drive_cycle();
        req_valid = '0;
        do_reset();
        for (int c = 0; c < 3; c++) drive_cycle();

        // Random traffic honouring the hold-while-waiting rule.
        last_w = -1;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && last_w != i)) begin
                    set_req(i, ($urandom % 3) != 0, $urandom % 2, AW'($urandom % 64), N'($urandom));
                end
            end
            drive_cycle();
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) drive_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
